// File: rtl/clksel_sequencer_if.sv
// Signal bundle between the clock-select sequencer, the clock controller and the CPU-side decode.
// The sequencer takes the slave view; whatever drives it takes the master view.
interface clksel_sequencer_if;
  logic lsclk_in;
  logic hsclk_selected;
  logic lsclk_selected;
  logic hs_en;
  logic ls_req;
  logic hsclk_sel;
  logic cpu_rdy;
  logic on_ls;
  logic switch_err;

  modport slave (
    input  lsclk_in, hsclk_selected, lsclk_selected, hs_en, ls_req,
    output hsclk_sel, cpu_rdy, on_ls, switch_err
  );

  modport master (
    output lsclk_in, hsclk_selected, lsclk_selected, hs_en, ls_req,
    input  hsclk_sel, cpu_rdy, on_ls, switch_err
  );
endinterface

// File: rtl/clksel_sequencer.sv
// Requesting side of the CPU fast/slow clock-switch handshake: drives hsclk_sel, stalls the CPU
// while a switch is in flight, holds the slow clock after host accesses and latches switch timeouts.
module clksel_sequencer #(
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic               hsclk_in,
  input  logic               rst_b,
  clksel_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_HS,
    ST_TO_LS,
    ST_LS,
    ST_TO_HS,
    ST_LOCK
  } state_e;

  localparam logic [3:0] HOLDOFF_LOAD = 4'(HOLDOFF_CYCLES);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] ls_sync_q;
  logic [SYNC_STAGES-1:0] hs_ack_sync_q;
  logic [SYNC_STAGES-1:0] ls_ack_sync_q;
  logic                   ls_prev_q;
  logic                   ls_s;
  logic                   hs_ack;
  logic                   ls_ack;
  logic                   ls_pulse;

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       timeout;
  logic       hsclk_sel_q, hsclk_sel_d;
  logic       cpu_rdy_q, cpu_rdy_d;
  logic       on_ls_q, on_ls_d;
  logic       switch_err_q, switch_err_d;

  assign ls_s     = ls_sync_q[SYNC_STAGES-1];
  assign hs_ack   = hs_ack_sync_q[SYNC_STAGES-1];
  assign ls_ack   = ls_ack_sync_q[SYNC_STAGES-1];
  assign ls_pulse = ls_s & ~ls_prev_q;
  assign timeout  = (to_cnt_q == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      ls_sync_q     <= '0;
      hs_ack_sync_q <= '0;
      ls_ack_sync_q <= '0;
      ls_prev_q     <= 1'b0;
    end else begin
      ls_sync_q     <= {ls_sync_q[SYNC_STAGES-2:0], bus.lsclk_in};
      hs_ack_sync_q <= {hs_ack_sync_q[SYNC_STAGES-2:0], bus.hsclk_selected};
      ls_ack_sync_q <= {ls_ack_sync_q[SYNC_STAGES-2:0], bus.lsclk_selected};
      ls_prev_q     <= ls_s;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    to_cnt_d = to_cnt_q;

    case (state_q)
      ST_HS: begin
        if (bus.ls_req || !bus.hs_en) state_d = ST_TO_LS;
      end
      ST_TO_LS: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (ls_ack && !hs_ack) begin
          state_d = ST_LS;
          hold_d  = HOLDOFF_LOAD;
        end else if (timeout) begin
          state_d = ST_LOCK;
        end
      end
      ST_LS: begin
        if (bus.ls_req) begin
          hold_d = HOLDOFF_LOAD;
        end else if (ls_pulse && hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end
        if (hold_q == 4'd0 && !bus.ls_req && bus.hs_en) state_d = ST_TO_HS;
      end
      ST_TO_HS: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (hs_ack && !ls_ack) begin
          state_d = ST_HS;
        end else if (timeout) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        state_d = ST_LOCK;
      end
      default: begin
        state_d = ST_LOCK;
      end
    endcase

    // The timeout count restarts whenever a new switch begins.
    if ((state_d == ST_TO_LS || state_d == ST_TO_HS) && state_d != state_q) to_cnt_d = 8'd0;

    hsclk_sel_d  = (state_d == ST_HS) || (state_d == ST_TO_HS);
    cpu_rdy_d    = (state_d == ST_HS) || (state_d == ST_LS) || (state_d == ST_LOCK);
    on_ls_d      = (state_d == ST_LS) || (state_d == ST_LOCK);
    switch_err_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_LS;
      hold_q       <= HOLDOFF_LOAD;
      to_cnt_q     <= 8'd0;
      hsclk_sel_q  <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      on_ls_q      <= 1'b1;
      switch_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      to_cnt_q     <= to_cnt_d;
      hsclk_sel_q  <= hsclk_sel_d;
      cpu_rdy_q    <= cpu_rdy_d;
      on_ls_q      <= on_ls_d;
      switch_err_q <= switch_err_d;
    end
  end

  assign bus.hsclk_sel  = hsclk_sel_q;
  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.on_ls      = on_ls_q;
  assign bus.switch_err = switch_err_q;

endmodule

// File: tb/tb_clksel_sequencer.sv
// Bench for clksel_sequencer: directed handshake scenarios followed by randomized traffic, with every
// cycle compared against a reference model built from input delay lines and switch timestamps.
module tb_clksel_sequencer;
  localparam int HOLDOFF = 4;
  localparam int TIMEOUT = 255;
  localparam int SYNC    = 2;

  localparam int M_HS    = 0;
  localparam int M_TO_LS = 1;
  localparam int M_LS    = 2;
  localparam int M_TO_HS = 3;
  localparam int M_LOCK  = 4;

  logic hsclk_in = 1'b0;
  logic rst_b;

  clksel_sequencer_if bus ();

  clksel_sequencer #(
    .HOLDOFF_CYCLES(HOLDOFF),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .hsclk_in(hsclk_in),
    .rst_b   (rst_b),
    .bus     (bus)
  );

  always #5 hsclk_in = ~hsclk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: mode, hold-off edges remaining, cycle stamp of the current switch start.
  int m_mode;
  int m_hold;
  int m_start;
  int cyc;
  bit h_ls[$];
  bit h_hsa[$];
  bit h_lsa[$];

  // Stimulus state: host clock generator and clock-controller model.
  int ls_cnt;
  int ls_rises;
  bit ls_rand;
  bit ctl_sel;
  bit ctl_mute;
  int ctl_wait;
  int ctl_dmin;
  int ctl_dmax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_LS;
    m_hold = HOLDOFF;
    h_ls.delete();
    h_hsa.delete();
    h_lsa.delete();
    for (int i = 0; i < SYNC + 2; i++) begin
      h_ls.push_back(1'b0);
      h_hsa.push_back(1'b0);
      h_lsa.push_back(1'b0);
    end
  endfunction

  // Synchronised values at an edge are the raw samples taken SYNC edges earlier.
  function automatic void model_edge(input bit ls, input bit hsa, input bit lsa,
                                     input bit hs_en, input bit ls_req);
    bit pulse, hs_ack, ls_ack;
    cyc++;
    h_ls.push_front(ls);
    h_hsa.push_front(hsa);
    h_lsa.push_front(lsa);
    pulse  = h_ls[SYNC] && !h_ls[SYNC+1];
    hs_ack = h_hsa[SYNC];
    ls_ack = h_lsa[SYNC];
    void'(h_ls.pop_back());
    void'(h_hsa.pop_back());
    void'(h_lsa.pop_back());

    case (m_mode)
      M_HS: if (ls_req || !hs_en) begin
        m_mode  = M_TO_LS;
        m_start = cyc;
      end
      M_TO_LS: begin
        if (ls_ack && !hs_ack) begin
          m_mode = M_LS;
          m_hold = HOLDOFF;
        end else if (cyc - m_start == TIMEOUT) begin
          m_mode = M_LOCK;
        end
      end
      M_LS: begin
        if (m_hold == 0 && !ls_req && hs_en) begin
          m_mode  = M_TO_HS;
          m_start = cyc;
        end
        if (ls_req) m_hold = HOLDOFF;
        else if (pulse && m_hold > 0) m_hold--;
      end
      M_TO_HS: begin
        if (hs_ack && !ls_ack) m_mode = M_HS;
        else if (cyc - m_start == TIMEOUT) m_mode = M_LOCK;
      end
      default: m_mode = M_LOCK;
    endcase
  endfunction

  function automatic logic m_out(input int which);
    case (which)
      0:       return (m_mode == M_HS) || (m_mode == M_TO_HS);
      1:       return (m_mode == M_HS) || (m_mode == M_LS) || (m_mode == M_LOCK);
      2:       return (m_mode == M_LS) || (m_mode == M_LOCK);
      default: return m_mode == M_LOCK;
    endcase
  endfunction

  function automatic logic dut_out(input int which);
    case (which)
      0:       return bus.hsclk_sel;
      1:       return bus.cpu_rdy;
      2:       return bus.on_ls;
      default: return bus.switch_err;
    endcase
  endfunction

  function automatic string out_name(input int which);
    case (which)
      0:       return "hsclk_sel";
      1:       return "cpu_rdy";
      2:       return "on_ls";
      default: return "switch_err";
    endcase
  endfunction

  task automatic drive_lsclk();
    if (ls_cnt <= 1) begin
      bus.lsclk_in = !bus.lsclk_in;
      if (bus.lsclk_in) ls_rises++;
      ls_cnt = ls_rand ? int'($urandom_range(6, 3)) : 4;
    end else begin
      ls_cnt--;
    end
  endtask

  // Controller model: drops both acknowledges on a select change, raises the new one after a delay.
  task automatic drive_ctl();
    if (bus.hsclk_sel !== ctl_sel) begin
      ctl_sel = bus.hsclk_sel;
      bus.hsclk_selected = 1'b0;
      bus.lsclk_selected = 1'b0;
      ctl_wait = int'($urandom_range(ctl_dmax, ctl_dmin));
    end else if (ctl_wait > 0) begin
      ctl_wait--;
      if (ctl_wait == 0 && !ctl_mute) begin
        if (ctl_sel) bus.hsclk_selected = 1'b1;
        else         bus.lsclk_selected = 1'b1;
      end
    end
  endtask

  task automatic ctl_reset();
    ctl_sel  = 1'b0;
    ctl_wait = 0;
    bus.hsclk_selected = 1'b0;
    bus.lsclk_selected = 1'b1;
  endtask

  task automatic step();
    @(posedge hsclk_in);
    model_edge(bus.lsclk_in, bus.hsclk_selected, bus.lsclk_selected, bus.hs_en, bus.ls_req);
    #1;
    for (int w = 0; w < 4; w++) check(out_name(w), dut_out(w), m_out(w));
    drive_lsclk();
    drive_ctl();
  endtask

  task automatic wait_out(input string tag, input int which, input logic val, input int budget,
                          output int n);
    n = 0;
    while (dut_out(which) !== val && n < budget) begin
      step();
      n++;
    end
    check(tag, dut_out(which), val);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous response, then releases it.
  task automatic apply_reset(input string tag);
    #3 rst_b = 1'b0;
    ctl_reset();
    #1;
    check({tag, "_sel"}, bus.hsclk_sel, 1'b0);
    check({tag, "_rdy"}, bus.cpu_rdy, 1'b1);
    check({tag, "_on_ls"}, bus.on_ls, 1'b1);
    check({tag, "_err"}, bus.switch_err, 1'b0);
    repeat (2) @(posedge hsclk_in);
    #1 rst_b = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int r0;
    int guard;
    bit saw_hs;

    rst_b        = 1'b1;
    bus.hs_en    = 1'b1;
    bus.ls_req   = 1'b0;
    bus.lsclk_in = 1'b0;
    ls_cnt       = 4;
    ls_rises     = 0;
    ls_rand      = 1'b0;
    ctl_mute     = 1'b0;
    ctl_dmin     = 10;
    ctl_dmax     = 10;
    cyc          = 0;
    m_start      = 0;
    model_reset();
    ctl_reset();

    // Start-up: slow clock out of reset, then hold-off expiry and switch to the fast clock.
    apply_reset("por");
    wait_out("startup_to_hs_rdy", 1, 1'b0, 200, n);
    check("startup_to_hs_sel", bus.hsclk_sel, 1'b1);
    wait_out("startup_hs_rdy", 1, 1'b1, 100, n);
    check("startup_hs_sel", bus.hsclk_sel, 1'b1);
    check("startup_hs_on_ls", bus.on_ls, 1'b0);

    // Single-cycle host access from HS.
    bus.ls_req = 1'b1;
    step();
    bus.ls_req = 1'b0;
    check("host_sel", bus.hsclk_sel, 1'b0);
    check("host_rdy", bus.cpu_rdy, 1'b0);
    wait_out("host_ls_rdy", 1, 1'b1, 100, n);
    check("host_on_ls", bus.on_ls, 1'b1);
    wait_out("host_back_to_hs", 0, 1'b1, 200, n);
    wait_out("host_hs_rdy", 1, 1'b1, 100, n);

    // Hold-off reload: a request every third host-clock period keeps the slow clock selected.
    bus.ls_req = 1'b1;
    step();
    bus.ls_req = 1'b0;
    wait_out("reload_on_ls", 2, 1'b1, 100, n);
    saw_hs = 1'b0;
    for (int p = 0; p < 6; p++) begin
      r0 = ls_rises;
      guard = 0;
      while (ls_rises - r0 < 3 && guard < 100) begin
        step();
        guard++;
        if (bus.hsclk_sel) saw_hs = 1'b1;
      end
      bus.ls_req = 1'b1;
      step();
      bus.ls_req = 1'b0;
      if (bus.hsclk_sel) saw_hs = 1'b1;
    end
    check("reload_no_to_hs", saw_hs, 1'b0);
    wait_out("reload_release_to_hs", 0, 1'b1, 200, n);
    wait_out("reload_hs_rdy", 1, 1'b1, 100, n);

    // Request arriving two cycles into TO_HS: that switch completes, then one HS cycle, then TO_LS.
    bus.ls_req = 1'b1;
    step();
    bus.ls_req = 1'b0;
    wait_out("req_tohs_ls", 2, 1'b1, 100, n);
    wait_out("req_tohs_enter", 0, 1'b1, 200, n);
    step();
    step();
    bus.ls_req = 1'b1;
    wait_out("req_tohs_hs_rdy", 1, 1'b1, 100, n);
    check("req_tohs_hs_sel", bus.hsclk_sel, 1'b1);
    step();
    check("req_tohs_to_ls_sel", bus.hsclk_sel, 1'b0);
    check("req_tohs_to_ls_rdy", bus.cpu_rdy, 1'b0);
    bus.ls_req = 1'b0;
    wait_out("req_tohs_back_ls", 2, 1'b1, 100, n);

    // Timeout: the controller never acknowledges the fast clock.
    ctl_mute = 1'b1;
    wait_out("timeout_enter", 0, 1'b1, 200, n);
    wait_out("timeout_err", 3, 1'b1, 400, n);
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_sel", bus.hsclk_sel, 1'b0);
    check("timeout_rdy", bus.cpu_rdy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      bus.hs_en  = 1'($urandom_range(1, 0));
      bus.ls_req = 1'($urandom_range(1, 0));
      step();
    end
    check("lock_held_err", bus.switch_err, 1'b1);
    check("lock_held_on_ls", bus.on_ls, 1'b1);
    bus.hs_en  = 1'b1;
    bus.ls_req = 1'b0;
    ctl_mute   = 1'b0;
    apply_reset("lock_rst");
    wait_out("lock_rst_to_hs", 0, 1'b1, 200, n);
    wait_out("lock_rst_hs_rdy", 1, 1'b1, 100, n);

    // Reset asserted in the middle of a switch towards the slow clock.
    bus.ls_req = 1'b1;
    step();
    bus.ls_req = 1'b0;
    step();
    step();
    check("mid_in_to_ls", bus.cpu_rdy, 1'b0);
    apply_reset("mid_rst");
    wait_out("mid_rst_to_hs", 0, 1'b1, 200, n);
    wait_out("mid_rst_hs_rdy", 1, 1'b1, 100, n);

    // Randomized traffic: host clock jitter, variable acknowledge delay, random requests and enable.
    ls_rand  = 1'b1;
    ctl_dmin = 1;
    ctl_dmax = 20;
    for (int i = 0; i < 3000; i++) begin
      bus.hs_en  = ($urandom_range(7, 0) != 0);
      bus.ls_req = ($urandom_range(15, 0) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clksel_sequencer.md
# clksel_sequencer

Clock-select sequencer: the requesting side of the CPU clock-switch handshake. Runs on `hsclk_in` and decides when the CPU clock moves between the fast (divided HSCLK) and slow (host motherboard) sources, driving `hsclk_sel` into the clock controller. It watches the controller's `hsclk_selected`/`lsclk_selected` acknowledges and stalls the 65816 via `cpu_rdy` while a switch is in flight. It holds the slow clock for a programmable number of host cycles after the last host-bus access, and flags a switch that never completes.

## Interface
Parameters:
- `HOLDOFF_CYCLES`, default 4: host-clock (lsclk) rising edges to remain on the slow clock after the last `ls_req`; legal range 1–15.
- `TIMEOUT_CYCLES`, default 255: `hsclk_in` cycles allowed for a switch acknowledge; legal range 8–255.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronisers; legal range 2–3.

Ports:
- `hsclk_in` input 1: clock; all logic is on the posedge.
- `rst_b` input 1: reset, asynchronous, active-low.
- `lsclk_in` input 1: raw host clock; asynchronous; synchronised, then rising-edge detected.
- `hsclk_selected` input 1: fast-clock-running acknowledge from the clock controller; asynchronous; synchronised.
- `lsclk_selected` input 1: slow-clock-running acknowledge; asynchronous; synchronised.
- `hs_en` input 1: turbo enable from the control register; synchronous to `hsclk_in`.
- `ls_req` input 1: the current bus cycle needs the host bus (address decode AND (VDA|VPA)); synchronous to `hsclk_in`.
- `hsclk_sel` output 1: registered clock-select request (1 = fast).
- `cpu_rdy` output 1: registered; 0 stalls the CPU.
- `on_ls` output 1: registered; 1 in states LS and LOCK.
- `switch_err` output 1: registered sticky timeout flag.

## Operation
- Synchronisers: `SYNC_STAGES` FFs each on `lsclk_in`, `hsclk_selected`, `lsclk_selected`, giving `ls_s`, `hs_ack`, `ls_ack`. The lsclk edge pulse is `ls_s & !ls_s_prev`.
- Rule for switches: a switch started is always completed. `ls_req` or `hs_en` changes during TO_LS or TO_HS take effect only after that switch completes.
- State machine, 5 states:
  - **HS**: `hsclk_sel`=1, `cpu_rdy`=1. Goes to TO_LS if `ls_req | !hs_en`.
  - **TO_LS**: `hsclk_sel`=0, `cpu_rdy`=0.
    - Goes to LS when `ls_ack & !hs_ack`; the hold-off counter loads `HOLDOFF_CYCLES`.
    - Goes to LOCK on timeout.
  - **LS**: `hsclk_sel`=0, `cpu_rdy`=1.
    - `ls_req` reloads the hold-off counter.
    - Otherwise an lsclk edge pulse decrements it, saturating at 0.
    - Goes to TO_HS when counter==0 & `!ls_req` & `hs_en`.
  - **TO_HS**: `hsclk_sel`=1, `cpu_rdy`=0.
    - Goes to HS when `hs_ack & !ls_ack`.
    - Goes to LOCK on timeout.
  - **LOCK**: `hsclk_sel`=0, `cpu_rdy`=1, `switch_err`=1. Exits only on reset.
- Timeout counter:
  - 8-bit; clears on entry to TO_LS or TO_HS; increments each cycle while in those states.
  - Timeout fires when count == `TIMEOUT_CYCLES`-1 and the acknowledge condition is still false.
  - If acknowledge and timeout are true in the same cycle, the acknowledge wins.
- Hold-off counter: 4-bit. Reload and decrement in the same cycle: reload wins.
- Reset: state LS, hold-off = `HOLDOFF_CYCLES`, timeout = 0, synchronisers = 0.
  - Output reset values: `hsclk_sel`=0, `cpu_rdy`=1, `on_ls`=1, `switch_err`=0. These match the clock controller's slow-clock reset state.
- Reset asserted mid-switch returns the block immediately to the reset state. The controller's own reset puts it on the slow clock, so the two stay consistent.

## Timing
- All outputs are registered and change one `hsclk_in` edge after the qualifying input is sampled.
- `ls_req` sampled high in HS: at the next edge `hsclk_sel`=0 and `cpu_rdy`=0.
- Acknowledge latency: `SYNC_STAGES` cycles of synchroniser delay, plus 1 cycle for the state update.
- Hold-off time: `HOLDOFF_CYCLES` lsclk rising edges. Each edge is seen `SYNC_STAGES`+1 `hsclk_in` cycles after the raw edge.
- Minimum LS dwell without further requests: `HOLDOFF_CYCLES` lsclk periods. TO_HS is entered on the edge after the counter reaches 0.
- `lsclk_in` must be slower than `hsclk_in`/4; the edge detector assumes one pulse per lsclk period.

## Test plan
- **Reset/start-up**: `hs_en`=1, `ls_req`=0, controller model acknowledges after 10 cycles.
  - Outputs at reset: `hsclk_sel`=0, `cpu_rdy`=1, `on_ls`=1.
  - After 4 lsclk edges: TO_HS with `cpu_rdy`=0.
  - Then HS with `hsclk_sel`=1, `cpu_rdy`=1, `on_ls`=0.
- **Host access from HS**: single-cycle `ls_req` pulse.
  - Next edge: `hsclk_sel`=0, `cpu_rdy`=0.
  - After acknowledge + 3 cycles: `cpu_rdy`=1, `on_ls`=1.
  - After 4 lsclk edges with no request: returns to HS.
- **Hold-off reload**: `ls_req` pulsed on every 3rd lsclk period while in LS.
  - No TO_HS ever occurs.
  - Stop the pulses: TO_HS follows exactly 4 lsclk edges after the last pulse.
- **Request during TO_HS**: `ls_req`=1 two cycles into TO_HS.
  - Switch completes to HS (one cycle with `cpu_rdy`=1), then TO_LS on the following edge.
- **Timeout**: controller model never acknowledges in TO_HS.
  - After 255 cycles: `switch_err`=1, `hsclk_sel`=0, `cpu_rdy`=1.
  - Stays in LOCK regardless of `hs_en`/`ls_req`; cleared only by `rst_b`.
- **Reset mid-switch**: `rst_b` asserted during TO_LS.
  - Outputs return to their reset values asynchronously.
  - `switch_err`=0; normal start-up sequence resumes after release.
